// File: rtl/seg_display_scanner.sv
// Four-digit multiplexed seven-segment scanner.
// Holds a 16-bit value written by the CPU and lights one digit at a time,
// DIV clock cycles per digit, with optional leading-zero blanking.
// Segments and anodes are both active-low and registered.
module seg_display_scanner #(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic        sel,
    output logic [6:0]  out,
    output logic [3:0]  decoderout
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic [1:0]    idx_reg;
    logic [15:0]   disp_reg;

    logic [6:0]    digit_seg [4];
    logic [3:0]    digit_blank;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Per-digit decode and blanking. A digit above zero is blank when it and
    // every more significant nibble are zero; digit 0 always shows.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign digit_seg[gi] = hex_to_seg(disp_reg[4*gi +: 4]);
            if (gi == 0) begin : g_first
                assign digit_blank[gi] = 1'b0;
            end else begin : g_upper
                assign digit_blank[gi] = sel && (disp_reg[15:4*gi] == '0);
            end
        end
    endgenerate

    // Select the currently scanned digit from the pre-edge index.
    always_comb begin
        seg_next = digit_blank[idx_reg] ? 7'h7F : digit_seg[idx_reg];
        an_next  = ~(4'b0001 << idx_reg);
    end

    // Display value capture, prescaler, digit index and registered pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= '0;
            idx_reg    <= 2'd0;
            disp_reg   <= 16'h0000;
            out        <= 7'h7F;
            decoderout <= 4'hF;
        end else begin
            if (load) begin
                disp_reg <= data_in;
            end
            if (cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
                idx_reg <= idx_reg + 2'd1;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            out        <= seg_next;
            decoderout <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scoreboard bench for seg_display_scanner (DIV=4). The driver predicts the
// pins for every upcoming edge from elapsed cycles and the last loaded value;
// a monitor pops one prediction per edge and compares.
module tb_seg_display_scanner;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic        sel = 1'b0;
    logic [6:0]  out;
    logic [3:0]  decoderout;

    bit          clk_run = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic [10:0] sb [$];
    int          m_cyc = 0;
    logic [15:0] m_disp = 16'h0000;
    logic        cur_sel = 1'b0;
    logic [6:0]  seg_tab [16];

    seg_display_scanner #(.DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .sel        (sel),
        .out        (out),
        .decoderout (decoderout)
    );

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got out=%02h an=%h, expected out=%02h an=%h (cycle %0d)",
                     name, act[10:4], act[3:0], exp[10:4], exp[3:0], m_cyc);
        end
    endtask

    // Pins a display should show: digit index advances every DIV cycles,
    // a digit is blank in sel mode when it lies above the top non-zero nibble.
    function automatic logic [10:0] model_pins(input int cyc, input logic [15:0] v, input logic s);
        int d;
        int top;
        logic [3:0] nib;
        logic [6:0] seg;
        logic [3:0] an;
        d   = (cyc / DIV) % 4;
        top = -1;
        for (int i = 0; i < 4; i++) if (((v >> (4*i)) & 16'hF) != 0) top = i;
        nib = 4'((v >> (4*d)) & 16'hF);
        seg = (s && d > 0 && d > top) ? 7'h7F : seg_tab[nib];
        an  = 4'hF & ~(4'(1) << d);
        return {seg, an};
    endfunction

    task automatic drive(input logic l, input logic [15:0] d, input logic s);
        load    = l;
        data_in = d;
        sel     = s;
        cur_sel = s;
        sb.push_back(model_pins(m_cyc, m_disp, s));
        if (l) m_disp = d;
        m_cyc++;
    endtask

    task automatic step(input logic l, input logic [15:0] d, input logic s);
        @(negedge clk);
        drive(l, d, s);
    endtask

    task automatic idle(input int n, input logic s);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, s);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #1 rst = 1'b0;
        #1 chk("reset_async", {out, decoderout}, {7'h7F, 4'hF});
        #1 rst = 1'b1;
        m_cyc  = 0;
        m_disp = 16'h0000;
        drive(1'b0, 16'h0000, cur_sel);
    endtask

    // Monitor: every edge out of reset presents one digit; compare it.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst && sb.size() > 0) chk("pins", {out, decoderout}, sb.pop_front());
    end

    initial begin
        logic [6:0]  o24 [5];
        logic [3:0]  a24 [5];
        logic [15:0] r;
        int          k;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        o24 = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h19};
        a24 = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

        // Reset with clock stopped, then first edge shows "0" on digit 0.
        #2 rst = 1'b0;
        #1 chk("reset_stopped", {out, decoderout}, {7'h7F, 4'hF});
        #5 rst = 1'b1;
        drive(1'b1, 16'h1234, 1'b0);
        clk_run = 1'b1;
        @(posedge clk);
        #1 chk("first_edge", {out, decoderout}, {7'h40, 4'hE});

        // Hex scan of 1234: spot checks on each digit change.
        for (int e = 2; e <= 18; e++) begin
            step(1'b0, 16'h0000, 1'b0);
            @(posedge clk);
            #1;
            if ((e - 2) % 4 == 0)
                chk("scan_1234", {out, decoderout}, {o24[(e-2)/4], a24[(e-2)/4]});
        end

        // Blanking patterns.
        step(1'b1, 16'h00A5, 1'b1); idle(17, 1'b1);
        step(1'b1, 16'h0000, 1'b1); idle(17, 1'b1);
        step(1'b1, 16'h1000, 1'b1); idle(17, 1'b1);

        // Load coinciding with the digit 0 -> 1 wrap.
        rst_pulse();
        idle(2, 1'b0);
        step(1'b1, 16'h000F, 1'b0);
        idle(16, 1'b0);

        // Mid-scan reset with BEEF held, scanning digit 2.
        step(1'b1, 16'hBEEF, 1'b0);
        while ((m_cyc / DIV) % 4 != 2) step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        rst_pulse();
        idle(6, 1'b0);

        // Mode switch while 000C sits on digit 2.
        step(1'b1, 16'h000C, 1'b0);
        while ((m_cyc / DIV) % 4 != 2) step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        idle(1, 1'b1);
        idle(12, 1'b1);

        // Back-to-back loads.
        step(1'b1, 16'h1111, 1'b0);
        step(1'b1, 16'h2222, 1'b0);
        step(1'b1, 16'h0030, 1'b1);
        idle(16, 1'b1);

        // Randomised traffic with occasional mid-scan resets.
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 99);
            if (k < 2) begin
                rst_pulse();
            end else begin
                r = 16'($urandom);
                r = r >> (4 * $urandom_range(0, 3));
                step(k < 25, r, (k > 94) ? ~cur_sel : cur_sel);
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_scanner.md
SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 The block SHALL have one clock and one asynchronous active-low reset; ports are named clk and rst as in the CPU, and rst is active-low.
REQ-002 Parameter DIV SHALL default to 50000; it is the number of clk cycles each digit is lit, and legal values are 2 or more.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 load  input  1  capture strobe from the CPU writeback stage.
REQ-006 data_in  input  16  value to display; nibble i drives digit i, digit 0 rightmost.
REQ-007 sel  input  1  mode: 0 = all four hex digits; 1 = leading-zero blanking.
REQ-008 out  output  7  segments, active-low, order {g,f,e,d,c,b,a} (bit6 = g, bit0 = a).
REQ-009 decoderout  output  4  digit anodes, active-low, one-hot-low; bit i selects digit i.

Function
REQ-010 Display register disp_q (16 bits) SHALL load data_in on a rising edge with load=1, and hold otherwise.
REQ-011 Prescaler cnt SHALL count 0..DIV-1 every cycle.
- At DIV-1, cnt wraps to 0 and digit index idx (2 bits) increments modulo 4 (3 -> 0) on the same edge.
REQ-012 out and decoderout SHALL be registered and computed from the pre-edge idx, disp_q and sel.
- Latency from a load edge, idx change or sel change to the pins is exactly 1 cycle.
REQ-013 decoderout SHALL equal ~(4'b0001 << idx) whenever rst is high.
REQ-014 Hex-to-segment encoding for nibble 0..F SHALL be: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, active-low).
REQ-015 With sel=1, digit i (i=1..3) SHALL be blanked (out=7F) when disp_q nibbles i..3 are all zero.
- Digit 0 is never blanked.
- Zeros below the most significant non-zero nibble are never blanked.
REQ-016 With sel=0, no digit SHALL be blanked.
REQ-017 When load and a cnt wrap occur on the same edge, both SHALL take effect, so the next displayed digit shows the new value.
REQ-018 Back-to-back loads SHALL each be captured; the last one wins and no load is dropped or delayed.
REQ-019 The block SHALL have no handshake back to the CPU: load is always accepted.

Reset
REQ-020 While rst=0, all of the following SHALL hold asynchronously, with no clock edge required:
- cnt=0, idx=0, disp_q=0000;
- out=7F (all segments off);
- decoderout=F (all digits off).
REQ-021 On the first rising edge after rst rises, out SHALL be 40 and decoderout SHALL be E (digit 0 shows "0").
REQ-022 Asserting rst mid-scan SHALL discard the in-progress digit and the held value; the scan restarts at digit 0.

Verification (DIV=4)
REQ-023 Reset check:
- drive rst=0 with clk stopped -> out=7F, decoderout=F immediately;
- release rst -> first edge gives out=40, decoderout=E.
REQ-024 Hex scan, sel=0, load 1234:
- decoderout cycles E,D,B,7,E, each held 4 cycles;
- matching out values 19,30,24,79,19.
REQ-025 Blanking, sel=1:
- load 00A5 -> digits 0..3 give out 12,08,7F,7F;
- load 0000 -> 40,7F,7F,7F;
- load 1000 -> 40,40,40,79.
REQ-026 Simultaneous load and wrap:
- pulse load with 000F on the edge where cnt wraps from digit 0 to digit 1;
- the next cycle shows decoderout=D, out=40;
- the following wrap back to digit 0 shows out=0E.
REQ-027 Mid-scan reset:
- load BEEF, scan to idx=2, pulse rst low between edges -> out=7F, decoderout=F immediately;
- after release, out=40, decoderout=E (value cleared).
REQ-028 Mode switch: toggling sel 0 -> 1 while 000C is displayed on digit 2 SHALL change out from 40 to 7F exactly 1 cycle after the toggle edge.
